// File: rtl/titan_branch_ctrl.sv
// Titan branch controller: sequences the branch comparator for one conditional branch at a time.
// Optional statistics counters are built when TITAN_BRANCH_STATS_EN is defined.
module titan_branch_ctrl #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid_i,
    output logic            br_ready_o,
    input  logic [2:0]      br_op_i,
    input  logic [XLEN-1:0] br_pc_i,
    input  logic [XLEN-1:0] br_imm_i,
    input  logic            rs1_rdy_i,
    input  logic            rs2_rdy_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic [2:0]      cmp_sel_o,
    output logic [XLEN-1:0] cmp_drs1_o,
    output logic [XLEN-1:0] cmp_drs2_o,
    input  logic            cmp_take_i,
    output logic            res_valid_o,
    output logic            res_taken_o,
    output logic [XLEN-1:0] res_target_o,
    output logic            res_misalign_o,
    output logic            res_illegal_o,
    output logic            busy_o,
    output logic [31:0]     stat_br_cnt_o,
    output logic [31:0]     stat_taken_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE, S_DONE} state_e;

    localparam logic CHECK_ALIGN = (IALIGN == 32);

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] drs1_q, drs1_d;
    logic [XLEN-1:0] drs2_q, drs2_d;
    logic            taken_q, taken_d;
    logic            accept_s;
    logic            done_s;
    logic [XLEN-1:0] target_s;

    assign br_ready_o = (state_q == S_IDLE) & ~flush_i;
    assign accept_s   = br_valid_i & br_ready_o;

    // State register and latched branch context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            pc_q    <= '0;
            imm_q   <= '0;
            drs1_q  <= '0;
            drs2_q  <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            drs1_q  <= drs1_d;
            drs2_q  <= drs2_d;
            taken_q <= taken_d;
        end
    end

    // Next-state and latch-enable logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        drs1_d  = drs1_q;
        drs2_d  = drs2_q;
        taken_d = taken_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        op_d    = br_op_i;
                        pc_d    = br_pc_i;
                        imm_d   = br_imm_i;
                        taken_d = 1'b0;
                        // nop and illegal never touch the comparator
                        if ((br_op_i == 3'd0) || (br_op_i == 3'd7)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (rs1_rdy_i && rs2_rdy_i) begin
                        drs1_d  = rs1_data_i;
                        drs2_d  = rs2_data_i;
                        state_d = S_RESOLVE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_RESOLVE: begin
                    taken_d = cmp_take_i;
                    state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign cmp_sel_o  = (state_q == S_RESOLVE) ? op_q : 3'd0;
    assign cmp_drs1_o = drs1_q;
    assign cmp_drs2_o = drs2_q;
    assign busy_o     = (state_q != S_IDLE);

    // A flush arriving in DONE kills the pulse in the same cycle
    assign done_s         = (state_q == S_DONE) & ~flush_i;
    assign target_s       = pc_q + imm_q;
    assign res_valid_o    = done_s;
    assign res_taken_o    = done_s & taken_q;
    assign res_target_o   = done_s ? target_s : '0;
    assign res_misalign_o = done_s & taken_q & CHECK_ALIGN & (target_s[1:0] != 2'b00);
    assign res_illegal_o  = done_s & (op_q == 3'd7);

`ifdef TITAN_BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_taken_q;

    // Saturating resolution counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q    <= 32'd0;
            stat_taken_q <= 32'd0;
        end else if (res_valid_o) begin
            if (stat_br_q != 32'hFFFF_FFFF) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (res_taken_o && (stat_taken_q != 32'hFFFF_FFFF)) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
        end
    end

    assign stat_br_cnt_o    = stat_br_q;
    assign stat_taken_cnt_o = stat_taken_q;
`else
    assign stat_br_cnt_o    = 32'd0;
    assign stat_taken_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_titan_branch_ctrl.sv
// Scoreboard bench for titan_branch_ctrl: directed branches, flush/reset corner cases, stats.
module tb_titan_branch_ctrl;

    typedef struct {
        logic        tk;
        logic [31:0] tg;
        logic        mis;
        logic        ill;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid_i = 1'b0;
    logic        br_ready_o;
    logic [2:0]  br_op_i = 3'd0;
    logic [31:0] br_pc_i = 32'd0;
    logic [31:0] br_imm_i = 32'd0;
    logic        rs1_rdy_i = 1'b0;
    logic        rs2_rdy_i = 1'b0;
    logic [31:0] rs1_data_i = 32'd0;
    logic [31:0] rs2_data_i = 32'd0;
    logic        flush_i = 1'b0;
    logic [2:0]  cmp_sel_o;
    logic [31:0] cmp_drs1_o;
    logic [31:0] cmp_drs2_o;
    logic        cmp_take_i;
    logic        res_valid_o;
    logic        res_taken_o;
    logic [31:0] res_target_o;
    logic        res_misalign_o;
    logic        res_illegal_o;
    logic        busy_o;
    logic [31:0] stat_br_cnt_o;
    logic [31:0] stat_taken_cnt_o;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_br = 0;
    int   exp_tk = 0;

    titan_branch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid_i(br_valid_i), .br_ready_o(br_ready_o), .br_op_i(br_op_i),
        .br_pc_i(br_pc_i), .br_imm_i(br_imm_i),
        .rs1_rdy_i(rs1_rdy_i), .rs2_rdy_i(rs2_rdy_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
        .cmp_sel_o(cmp_sel_o), .cmp_drs1_o(cmp_drs1_o), .cmp_drs2_o(cmp_drs2_o),
        .cmp_take_i(cmp_take_i),
        .res_valid_o(res_valid_o), .res_taken_o(res_taken_o), .res_target_o(res_target_o),
        .res_misalign_o(res_misalign_o), .res_illegal_o(res_illegal_o), .busy_o(busy_o),
        .stat_br_cnt_o(stat_br_cnt_o), .stat_taken_cnt_o(stat_taken_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator stand-in: 0 whenever select is 0
    always_comb begin
        cmp_take_i = 1'b0;
        case (cmp_sel_o)
            3'd1: cmp_take_i = (cmp_drs1_o == cmp_drs2_o);
            3'd2: cmp_take_i = (cmp_drs1_o != cmp_drs2_o);
            3'd3: cmp_take_i = ($signed(cmp_drs1_o) <  $signed(cmp_drs2_o));
            3'd4: cmp_take_i = ($signed(cmp_drs1_o) >= $signed(cmp_drs2_o));
            3'd5: cmp_take_i = (cmp_drs1_o <  cmp_drs2_o);
            3'd6: cmp_take_i = (cmp_drs1_o >= cmp_drs2_o);
            default: cmp_take_i = 1'b0;
        endcase
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: pops one expectation per resolution pulse, otherwise checks quiet outputs
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_res: got res_valid=1 expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_cycle", cyc, e.cyc);
                    chk("res_taken", {31'd0, res_taken_o}, {31'd0, e.tk});
                    chk("res_target", res_target_o, e.tg);
                    chk("res_misalign", {31'd0, res_misalign_o}, {31'd0, e.mis});
                    chk("res_illegal", {31'd0, res_illegal_o}, {31'd0, e.ill});
                    exp_br++;
                    if (e.tk) exp_tk++;
                end
            end else begin
                chk("res_quiet", {res_taken_o, res_misalign_o, res_illegal_o, 29'd0} | res_target_o, 32'd0);
            end
            if (!busy_o) chk("sel_idle", {29'd0, cmp_sel_o}, 32'd0);
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!br_ready_o && g < 20) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 20) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] d1, input logic [31:0] d2, input int dly,
                         input logic e_tk, input logic [31:0] e_tg, input logic e_mis, input logic e_ill);
        exp_t e;
        int   g = 0;
        wait_ready();
        br_valid_i = 1'b1; br_op_i = op; br_pc_i = pc; br_imm_i = imm;
        e.tk = e_tk; e.tg = e_tg; e.mis = e_mis; e.ill = e_ill;
        e.cyc = cyc + (((op == 3'd0) || (op == 3'd7)) ? 1 : 3 + dly);
        q.push_back(e);
        @(posedge clk); #1;
        br_valid_i = 1'b0; br_op_i = 3'd0; br_pc_i = 32'hDEAD_BEEF; br_imm_i = 32'h0BAD_0BAD;
        if ((op != 3'd0) && (op != 3'd7)) begin
            rs1_data_i = d1; rs2_data_i = d2;
            for (int i = 0; i < dly; i++) begin
                rs1_rdy_i = 1'b1; rs2_rdy_i = 1'b0;
                @(negedge clk);
                chk("wait_sel", {29'd0, cmp_sel_o}, 32'd0);
                chk("wait_busy", {31'd0, busy_o}, 32'd1);
                @(posedge clk); #1;
            end
            rs1_rdy_i = 1'b1; rs2_rdy_i = 1'b1;
            @(posedge clk); #1;
            rs1_rdy_i = 1'b0; rs2_rdy_i = 1'b0;
            rs1_data_i = ~d1; rs2_data_i = ~d2 + 32'd1;
            @(negedge clk);
            chk("resolve_sel", {29'd0, cmp_sel_o}, {29'd0, op});
        end
        while (q.size() != 0 && g < 20) begin
            @(posedge clk); #1; g++;
        end
        if (q.size() != 0) begin
            chk("res_timeout", 32'd0, 32'd1);
            q.delete();
        end
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, br_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_res", {res_valid_o, res_taken_o, res_misalign_o, res_illegal_o, 28'd0} | res_target_o, 32'd0);
        chk("rst_cmp", {29'd0, cmp_sel_o} | cmp_drs1_o | cmp_drs2_o, 32'd0);
        chk("rst_stats", stat_br_cnt_o | stat_taken_cnt_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        //     op    pc            imm           rs1           rs2           dly tk    target        mis   ill
        issue(3'd1, 32'h0000_0100, 32'h0000_0020, 32'h0000_1234, 32'h0000_1234, 0, 1'b1, 32'h0000_0120, 1'b0, 1'b0);
        issue(3'd3, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b1, 32'h0000_0240, 1'b0, 1'b0);
        issue(3'd5, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, 32'h0000_0240, 1'b0, 1'b0);
        issue(3'd6, 32'h0000_0200, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b1, 32'h0000_01F0, 1'b0, 1'b0);
        issue(3'd2, 32'h0000_0300, 32'h0000_0008, 32'h0000_0005, 32'h0000_0006, 4, 1'b1, 32'h0000_0308, 1'b0, 1'b0);
        issue(3'd1, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0007, 32'h0000_0007, 0, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
        issue(3'd1, 32'h0000_0400, 32'h0000_0002, 32'h0000_0009, 32'h0000_0009, 0, 1'b1, 32'h0000_0402, 1'b1, 1'b0);
        issue(3'd2, 32'h0000_0400, 32'h0000_0002, 32'h0000_0009, 32'h0000_0009, 1, 1'b0, 32'h0000_0402, 1'b0, 1'b0);
        issue(3'd7, 32'h0000_0010, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 32'h0000_0014, 1'b0, 1'b1);
        issue(3'd0, 32'h0000_0020, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 32'h0000_0028, 1'b0, 1'b0);
        issue(3'd4, 32'h0000_0000, 32'h0000_0010, 32'h0000_0003, 32'h0000_0003, 0, 1'b1, 32'h0000_0010, 1'b0, 1'b0);

        // Flush while waiting for operands
        wait_ready();
        br_valid_i = 1'b1; br_op_i = 3'd2; br_pc_i = 32'h0000_0500; br_imm_i = 32'h0000_0010;
        @(posedge clk); #1;
        br_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        chk("flush_wait_busy", {31'd0, busy_o}, 32'd1);
        chk("flush_wait_ready", {31'd0, br_ready_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_wait_after", {30'd0, br_ready_o, busy_o}, 32'd2);

        // Flush in DONE of a second branch
        @(posedge clk); #1;
        br_valid_i = 1'b1; br_op_i = 3'd1; br_pc_i = 32'h0000_0600; br_imm_i = 32'h0000_0010;
        @(posedge clk); #1;
        br_valid_i = 1'b0; rs1_rdy_i = 1'b1; rs2_rdy_i = 1'b1; rs1_data_i = 32'd4; rs2_data_i = 32'd4;
        @(posedge clk); #1;
        rs1_rdy_i = 1'b0; rs2_rdy_i = 1'b0;
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_done_pulse", {31'd0, res_valid_o}, 32'd0);
        chk("flush_done_busy", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_done_after", {30'd0, br_ready_o, busy_o}, 32'd2);

        // Flush together with a request in IDLE: not accepted
        @(posedge clk); #1;
        br_valid_i = 1'b1; flush_i = 1'b1; br_op_i = 3'd1;
        @(negedge clk);
        chk("flush_idle_ready", {31'd0, br_ready_o}, 32'd0);
        @(posedge clk); #1;
        br_valid_i = 1'b0; flush_i = 1'b0; br_op_i = 3'd0;
        @(negedge clk);
        chk("flush_idle_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;

`ifdef TITAN_BRANCH_STATS_EN
        chk("stat_br", stat_br_cnt_o, exp_br);
        chk("stat_taken", stat_taken_cnt_o, exp_tk);
`else
        chk("stat_br", stat_br_cnt_o, 32'd0);
        chk("stat_taken", stat_taken_cnt_o, 32'd0);
`endif
        chk("resolved_count", exp_br, 32'd11);

        // Asynchronous reset in the middle of a branch
        br_valid_i = 1'b1; br_op_i = 3'd1; br_pc_i = 32'h0000_0700; br_imm_i = 32'h0000_0004;
        @(posedge clk); #1;
        br_valid_i = 1'b0; rs1_rdy_i = 1'b1; rs2_rdy_i = 1'b1; rs1_data_i = 32'd1; rs2_data_i = 32'd1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_drs", cmp_drs1_o | cmp_drs2_o, 32'd0);
        chk("arst_stats", stat_br_cnt_o | stat_taken_cnt_o, 32'd0);
        rs1_rdy_i = 1'b0; rs2_rdy_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        chk("arst_idle", {30'd0, br_ready_o, busy_o}, 32'd2);
        chk("arst_no_pulse", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
